alu_share_arbiter: RTL

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_arb_pkg.sv | 33 +++
 rtl/prv32_ALU.sv | 33 +++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU share arbiter: FSM state codes,
// ALU function encodings and the latched operation record.
// Pure declarations; no timing or flow-control behaviour.
package alu_arb_pkg;

  // Arbiter FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ALU function codes; any code not listed produces a zero result
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  // Operation captured at the request handshake
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  alufn;
    logic        id;
  } op_t;

endpackage

// File: rtl/prv32_ALU.sv
// Purely combinational 32-bit ALU using the team function encoding.
// Latency: zero cycles (combinational); no handshake.
// Backpressure: none; the caller registers inputs and output.
module prv32_ALU
  import alu_arb_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  logic [3:0]  alufn_i,
  output logic [31:0] r_o
);

  // Select the result for the requested function; unknown codes give zero
  always_comb begin
    r_o = 32'd0;
    case (alufn_i)
      ALU_ADD:   r_o = a_i + b_i;
      ALU_SUB:   r_o = a_i - b_i;
      ALU_PASSB: r_o = b_i;
      ALU_OR:    r_o = a_i | b_i;
      ALU_AND:   r_o = a_i & b_i;
      ALU_XOR:   r_o = a_i ^ b_i;
      ALU_SRL:   r_o = a_i >> shamt_i;
      ALU_SLL:   r_o = a_i << shamt_i;
      ALU_SRA:   r_o = $unsigned($signed(a_i) >>> shamt_i);
      ALU_SLT:   r_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  r_o = {31'd0, a_i < b_i};
      default:   r_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters (round-robin or fixed priority).
// Latency: handshake in cycle N, rsp_valid from cycle N+2; one op per 3 cycles max.
// Backpressure: RESP holds result while rsp_ready=0; no request accepted outside IDLE.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic [3:0]  req0_alufn,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  input  logic [3:0]  req1_alufn,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_r,
  output logic        rsp_id
);

  logic [1:0]  state_q, state_d;
  op_t         op_q, op_d;
  logic        last_q, last_d;
  logic [31:0] rsp_r_q, rsp_r_d;
  logic        rsp_id_q, rsp_id_d;

  logic        any_vld;
  logic        grant_id;
  logic        accept;
  logic [31:0] alu_r;

  // Pick the winning port; on a tie round-robin favours the port not served last
  always_comb begin
    any_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
    end else begin
      grant_id = req1_valid;
    end
    // Ready is suppressed while reset is asserted so no handshake can be seen
    accept     = (state_q == ST_IDLE) && !rst && any_vld;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // The shared ALU only ever sees registered operands
  prv32_ALU u_alu (
    .a_i     (op_q.a),
    .b_i     (op_q.b),
    .shamt_i (op_q.shamt),
    .alufn_i (op_q.alufn),
    .r_o     (alu_r)
  );

  // FSM next-state: capture in IDLE, compute in EXEC, hold result in RESP
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    last_d   = last_q;
    rsp_r_d  = rsp_r_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (grant_id) begin
            op_d = '{a: req1_a, b: req1_b, shamt: req1_shamt, alufn: req1_alufn, id: 1'b1};
          end else begin
            op_d = '{a: req0_a, b: req0_b, shamt: req0_shamt, alufn: req0_alufn, id: 1'b0};
          end
          last_d  = grant_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_r_d  = alu_r;
        rsp_id_d = op_q.id;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight op and makes port 0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      last_q   <= 1'b1;
      rsp_r_q  <= 32'd0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      last_q   <= last_d;
      rsp_r_q  <= rsp_r_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_r     = rsp_r_q;
  assign rsp_id    = rsp_id_q;

endmodule
